// File: rtl/median9_sched.sv
// -----------------------------------------------------------------------------
// median9_sched
//   Exact median of a 3x3 window of unsigned samples. A single three_sort
//   instance is reused over seven steps:
//     rows    -> sort each row into (S, M, L)
//     columns -> a = max of row minima, b = median of row medians,
//                c = min of row maxima
//     final   -> median = middle of (a, b, c)
//   One result every 8 cycles when the consumer is always ready.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous, active-low reset
//   win_in         9 samples; p[n] = win_in[8n+7:8n], row r = p[3r..3r+2]
//   win_valid_in   window offered
//   win_ready_out  window can be accepted this cycle
//   med_out        median result
//   med_valid_out  med_out valid; held until med_ready_in
//   med_ready_in   consumer accepts med_out
//   busy_out       high while a window is being processed (ROW0..FINAL)
// -----------------------------------------------------------------------------

// Combinational 3-input sorter: o_lo <= o_mid <= o_hi (unsigned).
module three_sort #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_mid,
  output logic [W-1:0] o_hi
);
  logic [W-1:0] w_x0, w_x1, w_t;

  assign w_x0  = (i_a < i_b) ? i_a : i_b;   // min(a,b)
  assign w_x1  = (i_a < i_b) ? i_b : i_a;   // max(a,b)
  assign o_hi  = (w_x1 < i_c) ? i_c  : w_x1;
  assign w_t   = (w_x1 < i_c) ? w_x1 : i_c; // min(max(a,b), c)
  assign o_lo  = (w_x0 < w_t) ? w_x0 : w_t;
  assign o_mid = (w_x0 < w_t) ? w_t  : w_x0;
endmodule

module median9_sched #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9*DATA_W-1:0]   win_in,
  input  logic                  win_valid_in,
  output logic                  win_ready_out,
  output logic [DATA_W-1:0]     med_out,
  output logic                  med_valid_out,
  input  logic                  med_ready_in,
  output logic                  busy_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_ROW0, S_ROW1, S_ROW2, S_COL_S, S_COL_M, S_COL_L, S_FINAL, S_DONE
  } state_t;

  state_t                      r_state, w_next;
  logic [9*DATA_W-1:0]         r_win;
  logic [2:0][DATA_W-1:0]      r_lo, r_mid, r_hi;   // per-row sorted values
  logic [DATA_W-1:0]           r_a, r_b, r_c;       // column results
  logic [DATA_W-1:0]           r_med;
  logic                        r_med_valid;

  logic                        w_accept;
  logic [DATA_W-1:0]           w_sa, w_sb, w_sc;
  logic [DATA_W-1:0]           w_lo, w_mid, w_hi;

  // A new window may enter from IDLE, or from DONE in the same cycle the
  // current result is consumed (back-to-back operation).
  assign win_ready_out = rst_n & ((r_state == S_IDLE) |
                                  ((r_state == S_DONE) & med_ready_in));
  assign w_accept      = win_valid_in & win_ready_out;
  assign busy_out      = (r_state != S_IDLE) & (r_state != S_DONE);
  assign med_out       = r_med;
  assign med_valid_out = r_med_valid;

  three_sort #(.W(DATA_W)) u_sort (
    .i_a  (w_sa),
    .i_b  (w_sb),
    .i_c  (w_sc),
    .o_lo (w_lo),
    .o_mid(w_mid),
    .o_hi (w_hi)
  );

  // Next-state and sorter operand selection.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_sa   = '0;
    w_sb   = '0;
    w_sc   = '0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_ROW0;
      S_ROW0: begin
        w_sa = r_win[0*DATA_W +: DATA_W];
        w_sb = r_win[1*DATA_W +: DATA_W];
        w_sc = r_win[2*DATA_W +: DATA_W];
        w_next = S_ROW1;
      end
      S_ROW1: begin
        w_sa = r_win[3*DATA_W +: DATA_W];
        w_sb = r_win[4*DATA_W +: DATA_W];
        w_sc = r_win[5*DATA_W +: DATA_W];
        w_next = S_ROW2;
      end
      S_ROW2: begin
        w_sa = r_win[6*DATA_W +: DATA_W];
        w_sb = r_win[7*DATA_W +: DATA_W];
        w_sc = r_win[8*DATA_W +: DATA_W];
        w_next = S_COL_S;
      end
      S_COL_S: begin
        w_sa = r_lo[0]; w_sb = r_lo[1]; w_sc = r_lo[2];
        w_next = S_COL_M;
      end
      S_COL_M: begin
        w_sa = r_mid[0]; w_sb = r_mid[1]; w_sc = r_mid[2];
        w_next = S_COL_L;
      end
      S_COL_L: begin
        w_sa = r_hi[0]; w_sb = r_hi[1]; w_sc = r_hi[2];
        w_next = S_FINAL;
      end
      S_FINAL: begin
        w_sa = r_a; w_sb = r_b; w_sc = r_c;
        w_next = S_DONE;
      end
      S_DONE: if (med_ready_in) w_next = w_accept ? S_ROW0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: all datapath registers are reset (not just control) so an aborted
  // window leaves no residue visible on med_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_lo        <= '0;
      r_mid       <= '0;
      r_hi        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_med       <= '0;
      r_med_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      // The window is captured whole so later input changes cannot leak in.
      if (w_accept) r_win <= win_in;
      case (r_state)
        S_ROW0:  begin r_lo[0] <= w_lo; r_mid[0] <= w_mid; r_hi[0] <= w_hi; end
        S_ROW1:  begin r_lo[1] <= w_lo; r_mid[1] <= w_mid; r_hi[1] <= w_hi; end
        S_ROW2:  begin r_lo[2] <= w_lo; r_mid[2] <= w_mid; r_hi[2] <= w_hi; end
        S_COL_S: r_a <= w_hi;    // max of row minima
        S_COL_M: r_b <= w_mid;   // median of row medians
        S_COL_L: r_c <= w_lo;    // min of row maxima
        S_FINAL: begin
          r_med       <= w_mid;
          r_med_valid <= 1'b1;
        end
        S_DONE:  if (med_ready_in) r_med_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median9_sched.sv
// -----------------------------------------------------------------------------
// tb_median9_sched
//   Directed-vector bench for median9_sched. Inputs are driven and outputs
//   sampled 1 ns after each rising edge. Expected medians are hand-computed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_median9_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] win_in;
  logic        win_valid_in;
  logic        win_ready_out;
  logic [7:0]  med_out;
  logic        med_valid_out;
  logic        med_ready_in;
  logic        busy_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  median9_sched #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .win_in       (win_in),
    .win_valid_in (win_valid_in),
    .win_ready_out(win_ready_out),
    .med_out      (med_out),
    .med_valid_out(med_valid_out),
    .med_ready_in (med_ready_in),
    .busy_out     (busy_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack(input logic [7:0] p [9]);
    logic [71:0] w;
    for (int n = 0; n < 9; n++) w[8*n +: 8] = p[n];
    return w;
  endfunction

  // Called right after the accept edge E0. Measures edges until
  // med_valid_out, counts busy cycles, checks the median. Optionally
  // scrambles win_in and holds win_valid_in high from ROW1 on.
  task automatic wait_result(input string tag, input logic [7:0] exp, input bit scramble);
    int cycles = 0;
    int busy_cnt;
    busy_cnt = busy_out ? 1 : 0;
    while (cycles < 20) begin
      step();
      cycles++;
      if (med_valid_out) break;
      if (busy_out) busy_cnt++;
      if (scramble && cycles == 1) begin
        win_in       = {9{8'hEE}};
        win_valid_in = 1'b1;
      end
      if (scramble && cycles >= 1 && cycles <= 5)
        check({tag, "_ready_while_busy"}, win_ready_out, 1'b0);
      if (scramble && cycles == 5) win_valid_in = 1'b0;
    end
    check({tag, "_latency"}, cycles, 7);
    check({tag, "_median"}, med_out, exp);
    check({tag, "_busy_cycles"}, busy_cnt, 7);
  endtask

  // Offer a window from an idle block with med_ready_in high; expect a
  // one-cycle valid pulse.
  task automatic run(input string tag, input logic [7:0] p [9], input logic [7:0] exp);
    win_in       = pack(p);
    win_valid_in = 1'b1;
    check({tag, "_ready"}, win_ready_out, 1'b1);
    step();
    win_valid_in = 1'b0;
    wait_result(tag, exp, 1'b0);
    step();
    check({tag, "_pulse"}, med_valid_out, 1'b0);
  endtask

  initial begin
    logic [7:0] v [9];
    logic [7:0] hold;

    rst_n        = 1'b0;
    win_in       = '0;
    win_valid_in = 1'b0;
    med_ready_in = 1'b1;
    repeat (2) step();
    check("rst_valid", med_valid_out, 1'b0);
    check("rst_busy",  busy_out,      1'b0);
    check("rst_med",   med_out,       8'h00);
    check("rst_ready", win_ready_out, 1'b0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", win_ready_out, 1'b1);

    // Descending ramp
    v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run("ramp", v, 8'd5);
    // Uniform windows
    v = '{9{8'h00}}; run("all00", v, 8'h00);
    v = '{9{8'h80}}; run("all80", v, 8'h80);
    v = '{9{8'hFF}}; run("allFF", v, 8'hFF);
    // Duplicates and extremes, permuted across rows
    v = '{8'd255, 8'd0, 8'd7, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0};
    run("dup7", v, 8'd7);
    v = '{8'd200, 8'd1, 8'd1, 8'd1, 8'd200, 8'd1, 8'd200, 8'd1, 8'd200};
    run("dup1", v, 8'd1);
    // Scattered distinct values
    v = '{8'd10, 8'd50, 8'd30, 8'd90, 8'd20, 8'd70, 8'd40, 8'd80, 8'd60};
    run("mixed", v, 8'd50);

    // Backpressure then back-to-back accept in DONE
    med_ready_in = 1'b0;
    v = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd8};  // median 4
    win_in = pack(v); win_valid_in = 1'b1;
    step();
    win_valid_in = 1'b0;
    wait_result("bp1", 8'd4, 1'b0);
    hold = med_out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_med",   med_out,       hold);
      check("bp_hold_valid", med_valid_out, 1'b1);
      check("bp_ready_low",  win_ready_out, 1'b0);
    end
    v = '{8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20}; // median 60
    win_in = pack(v); win_valid_in = 1'b1; med_ready_in = 1'b1;
    #1;
    check("b2b_ready", win_ready_out, 1'b1);
    step();
    win_valid_in = 1'b0;
    check("b2b_valid_drop", med_valid_out, 1'b0);
    check("b2b_busy",       busy_out,      1'b1);
    wait_result("bp2", 8'd60, 1'b0);
    step();

    // Input stability: scramble win_in during ROW1..COL_L
    v = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
    win_in = pack(v); win_valid_in = 1'b1;
    step();
    win_valid_in = 1'b0;
    wait_result("stable", 8'd55, 1'b1);
    step();
    check("stable_idle", busy_out, 1'b0);

    // Reset in COL_M
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    win_in = pack(v); win_valid_in = 1'b1;
    step();                       // E0 -> ROW0
    win_valid_in = 1'b0;
    repeat (4) step();            // ROW1, ROW2, COL_S, COL_M
    check("pre_rst_busy", busy_out, 1'b1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", med_valid_out, 1'b0);
    check("mid_rst_busy",  busy_out,      1'b0);
    check("mid_rst_med",   med_out,       8'h00);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", win_ready_out, 1'b1);
    v = '{8'd200, 8'd150, 8'd250, 8'd120, 8'd180, 8'd130, 8'd170, 8'd160, 8'd140};
    run("post_rst", v, 8'd160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
